demux_reg_bank: RTL

- Write-side counterpart of the 32:1 read multiplexer: decodes a 5-bit write address into one of 32 storage registers of BUS_WIDTH bits.
- Drives the full bank as one flat bus, Qout, that feeds the read multiplexer's Din directly.
- Adds per-byte write enables, an optional hardwired-zero register 0, a per-register valid mask, and a sequenced bank-clear operation.
- Sits as the register-file storage of the datapath. Read ports are the existing multiplexers on Qout.

---
 rtl/demux_reg_bank.sv | 92 +++++++++
 1 files changed

// File: rtl/demux_reg_bank.sv
// rtl/demux_reg_bank.sv - byte-enabled write-decoded register bank with valid mask and sequenced clear
module demux_reg_bank #(
    parameter int BUS_WIDTH = 32,
    parameter int SEL       = 5,
    parameter int ZERO_REG  = 1
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          WrEn,
    input  logic [SEL-1:0]                Addr,
    input  logic [BUS_WIDTH-1:0]          Din,
    input  logic [BUS_WIDTH/8-1:0]        ByteEn,
    input  logic                          ClrReq,
    output logic                          Busy,
    output logic                          WrAck,
    output logic [2**SEL-1:0]             Valid,
    output logic [BUS_WIDTH*(2**SEL)-1:0] Qout
);

    localparam int NREG  = 2**SEL;
    localparam int NLANE = BUS_WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state;
    state_t               state_next;
    logic [BUS_WIDTH-1:0] regs [NREG];
    logic [SEL-1:0]       cnt;
    logic                 wr_accept;
    logic                 addr_is_zero;

    assign addr_is_zero = (Addr == '0);

    always_comb begin
        state_next = state;
        wr_accept  = 1'b0;
        case (state)
            IDLE: begin
                wr_accept = WrEn && !((ZERO_REG != 0) && addr_is_zero);
                if (ClrReq) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt == {SEL{1'b1}}) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
            WrAck <= 1'b0;
            Valid <= '0;
            for (int n = 0; n < NREG; n++) begin
                regs[n] <= '0;
            end
        end else begin
            state <= state_next;
            WrAck <= wr_accept;
            // A write and a clear request in the same IDLE cycle both take effect;
            // the clear walk then erases the freshly written register in turn.
            if (wr_accept) begin
                Valid[Addr] <= 1'b1;
                for (int i = 0; i < NLANE; i++) begin
                    if (ByteEn[i]) begin
                        regs[Addr][8*i +: 8] <= Din[8*i +: 8];
                    end
                end
            end
            if (state == IDLE && ClrReq) begin
                cnt <= '0;
            end
            if (state == CLEAR) begin
                regs[cnt]  <= '0;
                Valid[cnt] <= 1'b0;
                cnt        <= cnt + 1'b1;
            end
        end
    end

    assign Busy = (state == CLEAR);

    for (genvar n = 0; n < NREG; n++) begin : g_qout
        assign Qout[n*BUS_WIDTH +: BUS_WIDTH] = regs[n];
    end

endmodule
